button_event_decoder: RTL and testbench

BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

---
 rtl/button_event_decoder.sv | 105 ++++++++++
 tb/tb_button_event_decoder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// Per-channel debounce and press classification: 2-flop sync, debounce counter, hold FSM.
// pressed follows raw level after DEBOUNCE_CYCLES+2 edges; short/long pulses are registered, one cycle.
module button_event_decoder #(
  parameter int N_BTN             = 4,
  parameter int DEBOUNCE_CYCLES   = 1000,
  parameter int LONG_PRESS_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] button,
  output logic [N_BTN-1:0] pressed,
  output logic [N_BTN-1:0] short_press,
  output logic [N_BTN-1:0] long_press,
  output logic             any_event
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(LONG_PRESS_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LONG = HW'(LONG_PRESS_CYCLES);

  typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic          sync1, sync2;
    logic [DW-1:0] db_cnt;
    logic          pressed_q;
    logic [HW-1:0] hold_cnt;
    state_t        state, state_nxt;
    logic          short_q, long_q, short_nxt, long_nxt;

    // Mismatch seen on DEBOUNCE_CYCLES consecutive edges commits the new level.
    always_ff @(posedge clk) begin
      if (reset) begin
        sync1     <= 1'b0;
        sync2     <= 1'b0;
        db_cnt    <= '0;
        pressed_q <= 1'b0;
      end else begin
        sync1 <= button[i];
        sync2 <= sync1;
        if (sync2 == pressed_q) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          pressed_q <= sync2;
          db_cnt    <= '0;
        end else if (db_cnt != '1) begin
          db_cnt <= db_cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state    <= IDLE;
        hold_cnt <= '0;
        short_q  <= 1'b0;
        long_q   <= 1'b0;
      end else begin
        state   <= state_nxt;
        short_q <= short_nxt;
        long_q  <= long_nxt;
        if (!pressed_q)
          hold_cnt <= '0;
        else if (state == IDLE)
          hold_cnt <= HW'(1);
        else if (hold_cnt != HOLD_LONG)
          hold_cnt <= hold_cnt + 1'b1;
      end
    end

    always_comb begin
      state_nxt = state;
      case (state)
        IDLE:    if (pressed_q) state_nxt = HELD;
        HELD:    if (!pressed_q) state_nxt = IDLE;
                 else if (hold_cnt == HOLD_LONG) state_nxt = LONG;
        LONG:    if (!pressed_q) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    // Release is checked first, so a release on the threshold edge yields a short press.
    always_comb begin
      short_nxt = 1'b0;
      long_nxt  = 1'b0;
      if (state == HELD) begin
        short_nxt = !pressed_q;
        long_nxt  = pressed_q && (hold_cnt == HOLD_LONG);
      end
    end

    assign pressed[i]     = pressed_q;
    assign short_press[i] = short_q;
    assign long_press[i]  = long_q;
  end

  always_ff @(posedge clk) begin
    if (reset)
      any_event <= 1'b0;
    else
      any_event <= |(short_press | long_press);
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with D=4, L=16; expected pulses queued per cycle.
module tb_button_event_decoder;

  typedef struct {
    int         cyc;
    logic [3:0] sp;
    logic [3:0] lp;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] button;
  logic [3:0] pressed, short_press, long_press;
  logic       any_event;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  exp_t q[$];
  logic [3:0] esp, elp;
  logic       exp_any = 1'b0;

  button_event_decoder #(
    .N_BTN(4), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .button(button), .pressed(pressed),
    .short_press(short_press), .long_press(long_press), .any_event(any_event)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(int at, logic [3:0] sp, logic [3:0] lp);
    exp_t e;
    e.cyc = at;
    e.sp  = sp;
    e.lp  = lp;
    q.push_back(e);
  endtask

  // Every cycle: pulses must match the queued expectation for that cycle (else zero),
  // and any_event must echo the previous cycle's expected pulses.
  always @(negedge clk) begin
    if (mon_en) begin
      esp = 4'b0;
      elp = 4'b0;
      if (q.size() != 0 && q[0].cyc == cyc) begin
        esp = q[0].sp;
        elp = q[0].lp;
        void'(q.pop_front());
      end
      check("short_press", short_press, esp);
      check("long_press", long_press, elp);
      check("any_event", any_event, exp_any);
      exp_any = |(esp | elp);
    end
  end

  initial begin
    int c, d;
    reset  = 1'b1;
    button = 4'b0;
    tick(3);
    check("rst_pressed", pressed, 0);
    check("rst_short", short_press, 0);
    check("rst_long", long_press, 0);
    check("rst_any", any_event, 0);
    reset  = 1'b0;
    mon_en = 1'b1;
    tick(2);

    // Latency and short press on button 0
    c = cyc;
    button[0] = 1'b1;
    tick(5);
    check("lat_edge5", pressed[0], 0);
    tick(1);
    check("lat_edge6", pressed[0], 1);
    tick(6);
    button[0] = 1'b0;
    push(c + 19, 4'b0001, 4'b0000);
    tick(20);
    check("a_released", pressed[0], 0);

    // 3-cycle glitch on button 1 is ignored
    button[1] = 1'b1;
    tick(3);
    button[1] = 1'b0;
    repeat (12) begin
      tick(1);
      check("glitch_pressed1", pressed[1], 0);
    end

    // 8-cycle debounced hold on button 2 -> short press, any_event one cycle later
    c = cyc;
    button[2] = 1'b1;
    tick(8);
    button[2] = 1'b0;
    push(c + 15, 4'b0100, 4'b0000);
    tick(7);
    check("c_short", short_press, 4'b0100);
    tick(1);
    check("c_any", any_event, 1);
    tick(20);

    // 40-cycle hold on button 3 -> long press, silent release
    c = cyc;
    button[3] = 1'b1;
    push(c + 23, 4'b0000, 4'b1000);
    tick(40);
    button[3] = 1'b0;
    tick(30);
    check("d_released", pressed[3], 0);

    // Simultaneous short releases on buttons 0 and 1
    c = cyc;
    button[1:0] = 2'b11;
    tick(10);
    button[1:0] = 2'b00;
    push(c + 17, 4'b0011, 4'b0000);
    tick(25);

    // Threshold boundary: ch0 releases on the threshold edge (short), ch1 one later (long)
    c = cyc;
    button[1:0] = 2'b11;
    tick(16);
    button[0] = 1'b0;
    tick(1);
    button[1] = 1'b0;
    push(c + 23, 4'b0001, 4'b0010);
    tick(30);

    // 3-cycle gap during a long hold on button 2 does not drop pressed
    c = cyc;
    button[2] = 1'b1;
    push(c + 23, 4'b0000, 4'b0100);
    tick(10);
    button[2] = 1'b0;
    tick(3);
    button[2] = 1'b1;
    repeat (8) begin
      tick(1);
      check("gap_pressed2", pressed[2], 1);
    end
    tick(4);
    button[2] = 1'b0;
    tick(30);

    // Reset mid-press on button 0 at hold count 10 aborts the press
    c = cyc;
    button[0] = 1'b1;
    tick(16);
    reset = 1'b1;
    tick(1);
    check("h_rst_pressed", pressed, 0);
    check("h_rst_short", short_press, 0);
    check("h_rst_long", long_press, 0);
    check("h_rst_any", any_event, 0);
    tick(1);
    reset = 1'b0;
    d = cyc;
    tick(5);
    check("h_relat5", pressed[0], 0);
    tick(1);
    check("h_relat6", pressed[0], 1);
    tick(2);
    button[0] = 1'b0;
    push(d + 15, 4'b0001, 4'b0000);
    tick(25);

    mon_en = 1'b0;
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
